// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcode field location and opcode encodings used by fetch and decode.
package cpu_pkg;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 27;
    localparam int unsigned IMM_WIDTH  = 12;

    localparam logic [4:0] OPC_ALU    = 5'b00000;
    localparam logic [4:0] OPC_ALUI   = 5'b00001;
    localparam logic [4:0] OPC_LOAD   = 5'b00100;
    localparam logic [4:0] OPC_STORE  = 5'b00101;
    localparam logic [4:0] OPC_BRANCH = 5'b10000;
    localparam logic [4:0] OPC_JUMP   = 5'b10010;
    localparam logic [4:0] OPC_HALT   = 5'b11111;

    function automatic logic [4:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC logic: folds unconditional JUMP, otherwise sequential PC + 1.
module fetch_next_pc
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  is_jump
);

    always_comb begin
        is_jump = (opcode_of(instr[31:0]) == OPC_JUMP);
        // Only the low address bits of the immediate matter; the rest are ignored.
        next_pc = is_jump ? instr[ADDR_WIDTH-1:0] : pc + ADDR_WIDTH'(1);
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, one-entry IF/ID output register with valid/ready, redirect flush
// and a wrapping count of completed handshakes.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] PC_Address,
    input  logic [DATA_WIDTH-1:0] Mem_Instruction,
    input  logic                  Fetch_Enable,
    input  logic                  Redirect_Valid,
    input  logic [ADDR_WIDTH-1:0] Redirect_Target,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [DATA_WIDTH-1:0] Out_Instruction,
    output logic [ADDR_WIDTH-1:0] Out_PC,
    output logic                  Out_Jump,
    output logic [15:0]           Fetch_Count
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_instr_q;
    logic [ADDR_WIDTH-1:0] out_pc_q;
    logic                  out_jump_q;
    logic [15:0]           fetch_count_q;

    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  is_jump;
    logic                  handshake;
    logic                  advance;

    fetch_next_pc #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_next_pc (
        .pc     (pc_q),
        .instr  (Mem_Instruction),
        .next_pc(next_pc),
        .is_jump(is_jump)
    );

    always_comb begin
        handshake = out_valid_q && Out_Ready;
        advance   = Fetch_Enable && (!out_valid_q || Out_Ready) && !Redirect_Valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            out_jump_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            // A handshake on a redirect cycle still counts even though the entry is flushed.
            if (handshake) begin
                fetch_count_q <= fetch_count_q + 16'd1;
            end
            if (Redirect_Valid) begin
                pc_q        <= Redirect_Target;
                out_valid_q <= 1'b0;
            end else if (advance) begin
                pc_q        <= next_pc;
                out_valid_q <= 1'b1;
                out_instr_q <= Mem_Instruction;
                out_pc_q    <= pc_q;
                out_jump_q  <= is_jump;
            end else if (handshake) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign PC_Address      = pc_q;
    assign Out_Valid       = out_valid_q;
    assign Out_Instruction = out_instr_q;
    assign Out_PC          = out_pc_q;
    assign Out_Jump        = out_jump_q;
    assign Fetch_Count     = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed program walk plus random handshake,
// redirect and enable traffic compared against a behavioural model of the fetch rules.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [7:0]  PC_Address;
    logic [31:0] Mem_Instruction;
    logic        Fetch_Enable;
    logic        Redirect_Valid;
    logic [7:0]  Redirect_Target;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Instruction;
    logic [7:0]  Out_PC;
    logic        Out_Jump;
    logic [15:0] Fetch_Count;

    int checks;
    int failures;

    logic [31:0] mem [256];

    // Reference model state
    logic [7:0]  m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [7:0]  m_out_pc;
    logic        m_jump;
    int          m_count;

    instruction_fetch #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .RESET_PC  (8'd0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PC_Address     (PC_Address),
        .Mem_Instruction(Mem_Instruction),
        .Fetch_Enable   (Fetch_Enable),
        .Redirect_Valid (Redirect_Valid),
        .Redirect_Target(Redirect_Target),
        .Out_Valid      (Out_Valid),
        .Out_Ready      (Out_Ready),
        .Out_Instruction(Out_Instruction),
        .Out_PC         (Out_PC),
        .Out_Jump       (Out_Jump),
        .Fetch_Count    (Fetch_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign Mem_Instruction = mem[PC_Address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("pc_address", {24'd0, PC_Address}, {24'd0, m_pc});
        check("out_valid", {31'd0, Out_Valid}, {31'd0, m_valid});
        check("out_pc", {24'd0, Out_PC}, {24'd0, m_out_pc});
        check("out_instruction", Out_Instruction, m_instr);
        check("out_jump", {31'd0, Out_Jump}, {31'd0, m_jump});
        check("fetch_count", {16'd0, Fetch_Count}, m_count % 65536);
    endtask

    task automatic model_reset();
        m_pc = 8'd0; m_valid = 1'b0; m_instr = 32'd0; m_out_pc = 8'd0; m_jump = 1'b0;
        m_count = 0;
    endtask

    // One clock of the fetch rules applied to the inputs currently driven.
    task automatic model_clock();
        bit          hs;
        bit          adv;
        logic [31:0] w;
        hs  = m_valid && Out_Ready;
        adv = Fetch_Enable && (!m_valid || Out_Ready) && !Redirect_Valid;
        if (hs) m_count = m_count + 1;
        if (Redirect_Valid) begin
            m_pc    = Redirect_Target;
            m_valid = 1'b0;
        end else if (adv) begin
            w        = mem[m_pc];
            m_instr  = w;
            m_out_pc = m_pc;
            m_valid  = 1'b1;
            m_jump   = (w[31:27] == 5'b10010);
            m_pc     = m_jump ? w[7:0] : 8'((int'(m_pc) + 1) % 256);
        end else if (hs) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic run_until_out_pc(input logic [7:0] target);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (Out_Valid && Out_PC == target) found = 1'b1;
        end
        check("reach_out_pc", {31'd0, found}, 32'd1);
    endtask

    function automatic logic [31:0] non_jump_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:27] == 5'b10010) w[31] = 1'b0;
        return w;
    endfunction

    initial begin
        logic [31:0] w;
        logic [15:0] held_count;
        checks = 0;
        failures = 0;

        // Standard program: sequential code, a JUMP at 27 to 35, random jumps at 64..249.
        for (int i = 0; i < 256; i++) begin
            if (i >= 64 && i < 250 && (i % 5) == 0) begin
                w = $urandom;
                w[31:27] = 5'b10010;
                mem[i] = w;
            end else begin
                mem[i] = non_jump_word();
            end
        end
        mem[0]  = 32'h00443000;
        mem[27] = 32'h90000023;

        rst_n = 1'b0;
        Fetch_Enable = 1'b0;
        Redirect_Valid = 1'b0;
        Redirect_Target = 8'd0;
        Out_Ready = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Back-to-back fetch from reset
        Fetch_Enable = 1'b1;
        Out_Ready = 1'b1;
        step();
        check("first_out_pc", {24'd0, Out_PC}, 32'd0);
        check("first_instr", Out_Instruction, 32'h00443000);
        check("first_valid", {31'd0, Out_Valid}, 32'd1);
        step();
        check("second_out_pc", {24'd0, Out_PC}, 32'd1);
        step();
        check("third_out_pc", {24'd0, Out_PC}, 32'd2);
        step();
        check("count_after_3", {16'd0, Fetch_Count}, 32'd3);

        // Stall at Out_PC=5
        run_until_out_pc(8'd5);
        Out_Ready = 1'b0;
        held_count = Fetch_Count;
        repeat (3) begin
            step();
            check("stall_out_pc", {24'd0, Out_PC}, 32'd5);
            check("stall_pc_address", {24'd0, PC_Address}, 32'd6);
            check("stall_count", {16'd0, Fetch_Count}, {16'd0, held_count});
        end
        Out_Ready = 1'b1;
        step();
        check("after_stall_out_pc", {24'd0, Out_PC}, 32'd6);

        // Folded JUMP at 27 -> 35 with no bubble
        run_until_out_pc(8'd26);
        step();
        check("jump_out_pc", {24'd0, Out_PC}, 32'd27);
        check("jump_instr", Out_Instruction, 32'h90000023);
        check("jump_flag", {31'd0, Out_Jump}, 32'd1);
        step();
        check("target_out_pc", {24'd0, Out_PC}, 32'd35);
        check("target_valid", {31'd0, Out_Valid}, 32'd1);
        check("target_jump_flag", {31'd0, Out_Jump}, 32'd0);
        step();
        check("target_plus1_out_pc", {24'd0, Out_PC}, 32'd36);

        // Redirect to 40 while holding Out_PC=28 with Out_Ready low
        Redirect_Valid = 1'b1; Redirect_Target = 8'd28;
        step();
        Redirect_Valid = 1'b0;
        step();
        check("redir28_out_pc", {24'd0, Out_PC}, 32'd28);
        Out_Ready = 1'b0;
        Redirect_Valid = 1'b1; Redirect_Target = 8'd40;
        held_count = Fetch_Count;
        step();
        check("redir_flush_valid", {31'd0, Out_Valid}, 32'd0);
        check("redir_flush_count", {16'd0, Fetch_Count}, {16'd0, held_count});
        Redirect_Valid = 1'b0;
        Out_Ready = 1'b1;
        step();
        check("redir40_out_pc", {24'd0, Out_PC}, 32'd40);
        check("redir40_valid", {31'd0, Out_Valid}, 32'd1);

        // PC wrap 255 -> 0
        Redirect_Valid = 1'b1; Redirect_Target = 8'd255;
        step();
        Redirect_Valid = 1'b0;
        step();
        check("wrap_out_pc_255", {24'd0, Out_PC}, 32'd255);
        step();
        check("wrap_out_pc_0", {24'd0, Out_PC}, 32'd0);

        // Asynchronous reset mid-run at Out_PC=12
        run_until_out_pc(8'd12);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_valid", {31'd0, Out_Valid}, 32'd0);
        check("async_rst_count", {16'd0, Fetch_Count}, 32'd0);
        check("async_rst_out_pc", {24'd0, Out_PC}, 32'd0);
        check_all();
        #2 rst_n = 1'b1;
        step();
        check("restart_out_pc", {24'd0, Out_PC}, 32'd0);
        check("restart_valid", {31'd0, Out_Valid}, 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            Fetch_Enable    = ($urandom_range(0, 9) < 8);
            Out_Ready       = ($urandom_range(0, 9) < 7);
            Redirect_Valid  = ($urandom_range(0, 9) == 0);
            Redirect_Target = 8'($urandom_range(0, 255));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
